// File: rtl/count_sequencer.sv
// Round-robin sequencer sharing one countdown unit among N_REQ requesters.
// Launches a count, waits for finalSignal, returns the counter to idle, reports done.
module count_sequencer #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk_out,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             cnt_final,
   output logic             cnt_init,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] done,
   output logic             timeout,
   output logic             busy
);

   localparam int unsigned OW = $clog2(N_REQ);
   localparam int unsigned WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WdLast  = WW'(TIMEOUT - 1);
   localparam logic [OW-1:0] PtrInit = OW'(N_REQ - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStart   = 3'd1,
      StWaitFin = 3'd2,
      StRelease = 3'd3,
      StWaitClr = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          expired_q, expired_d;  // current transaction was aborted by the watchdog
   logic          timeout_q, timeout_d;
   logic [OW-1:0] pick;

   // Walk from farthest to nearest so the first set bit after rr_ptr wins.
   always_comb begin
      pick = rr_ptr_q;
      for (int unsigned k = N_REQ; k >= 1; k--) begin
         int unsigned idx;
         idx = 32'(rr_ptr_q) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (req[OW'(idx)]) begin
            pick = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      wd_d      = '0;
      expired_d = expired_q;
      timeout_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (|req) begin
               owner_d   = pick;
               expired_d = 1'b0;
               state_d   = StStart;
            end
         end
         StStart: begin
            state_d = StWaitFin;
         end
         StWaitFin: begin
            if (cnt_final) begin
               state_d = StRelease;
            end else if (wd_q == WdLast) begin
               timeout_d = 1'b1;
               expired_d = 1'b1;
               state_d   = StRelease;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         StRelease: begin
            state_d = StWaitClr;
         end
         StWaitClr: begin
            if (!cnt_final) begin
               rr_ptr_d = owner_q;
               state_d  = StIdle;
            end else if (wd_q == WdLast) begin
               timeout_d = 1'b1;
               rr_ptr_d  = owner_q;
               state_d   = StIdle;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_out) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         rr_ptr_q  <= PtrInit;
         wd_q      <= '0;
         expired_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         wd_q      <= wd_d;
         expired_q <= expired_d;
         timeout_q <= timeout_d;
      end
   end

   // Outputs decode registered state only, so they are glitch-free.
   always_comb begin
      logic             in_txn;
      logic [N_REQ-1:0] owner_oh;
      owner_oh = N_REQ'(1) << owner_q;
      in_txn   = 1'b0;
      cnt_init = 1'b0;
      done     = '0;
      case (state_q)
         StStart: begin
            in_txn   = 1'b1;
            cnt_init = 1'b1;
         end
         StWaitFin: begin
            in_txn = 1'b1;
         end
         StRelease: begin
            in_txn   = 1'b1;
            cnt_init = 1'b1;
            done     = expired_q ? '0 : owner_oh;
         end
         StWaitClr: begin
            in_txn = 1'b1;
         end
         default: begin
            in_txn = 1'b0;
         end
      endcase
      busy    = in_txn;
      grant   = in_txn ? owner_oh : '0;
      timeout = timeout_q;
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: countdown-unit model, transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed timing.
module tb_count_sequencer;

   localparam int N = 4;
   localparam int T = 64;
   localparam int PhIdle = 0, PhStart = 1, PhWaitFin = 2, PhRelease = 3, PhWaitClr = 4;

   logic         clk_out = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req = '0;
   logic         cnt_final = 1'b0;
   logic         cnt_init, timeout, busy;
   logic [N-1:0] grant, done;

   count_sequencer #(.N_REQ(N), .TIMEOUT(T)) dut (
      .clk_out   (clk_out),
      .reset     (reset),
      .req       (req),
      .cnt_final (cnt_final),
      .cnt_init  (cnt_init),
      .grant     (grant),
      .done      (done),
      .timeout   (timeout),
      .busy      (busy)
   );

   always #5 clk_out = ~clk_out;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Countdown unit: init while idle starts a 15-step count, init while final returns to idle.
   int cd_cnt = 0, cd_clr = 0, cd_hold = 0;
   bit cd_stuck = 0;
   initial begin : countdown
      forever begin
         @(negedge clk_out);
         if (reset) begin
            cd_cnt = 0; cd_clr = 0; cnt_final = 1'b0;
         end else if (cnt_init) begin
            if (cnt_final) begin
               if (cd_hold == 0) cnt_final = 1'b0;
               else cd_clr = cd_hold;
            end else if (!cd_stuck) begin
               cd_cnt = 15;
            end
         end else if (cd_clr > 0) begin
            cd_clr--;
            if (cd_clr == 0) cnt_final = 1'b0;
         end else if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) cnt_final = 1'b1;
         end
      end
   end

   // Event logs filled by the monitor.
   logic [N-1:0] g_log[$];
   int g_cyc[$];
   logic [N-1:0] d_log[$];
   int d_cyc[$];
   int t_cyc[$];
   int f_cyc[$];
   int b_fall = -1;

   // Reference model: phase of the current transaction plus cycles spent waiting.
   int m_ph = PhIdle, m_owner = 0, m_last = N - 1, m_cnt = 0;
   bit m_to = 0, m_abort = 0;

   initial begin : compare
      logic [N-1:0] s_req, prev_grant;
      logic s_fin, s_rst, prev_busy, prev_fin;
      logic [31:0] e_grant, e_done;
      bit found, e_busy;
      prev_grant = '0; prev_busy = 1'b0; prev_fin = 1'b0;
      forever begin
         @(posedge clk_out);
         s_req = req; s_fin = cnt_final; s_rst = reset;
         cyc++;
         if (s_rst) begin
            m_ph = PhIdle; m_last = N - 1; m_cnt = 0; m_to = 0; m_abort = 0;
         end else begin
            m_to = 0;
            case (m_ph)
               PhIdle: if (s_req != 0) begin
                  found = 0;
                  for (int k = 1; k <= N; k++) begin
                     if (!found && s_req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N; found = 1;
                     end
                  end
                  m_ph = PhStart; m_abort = 0;
               end
               PhStart: begin m_ph = PhWaitFin; m_cnt = 0; end
               PhWaitFin: begin
                  m_cnt++;
                  if (s_fin) m_ph = PhRelease;
                  else if (m_cnt == T) begin m_ph = PhRelease; m_abort = 1; m_to = 1; end
               end
               PhRelease: begin m_ph = PhWaitClr; m_cnt = 0; end
               default: begin
                  m_cnt++;
                  if (!s_fin) begin m_ph = PhIdle; m_last = m_owner; end
                  else if (m_cnt == T) begin m_ph = PhIdle; m_last = m_owner; m_to = 1; end
               end
            endcase
         end
         #1;
         e_busy  = (m_ph != PhIdle);
         e_grant = e_busy ? (32'd1 << m_owner) : 32'd0;
         e_done  = (m_ph == PhRelease && !m_abort) ? (32'd1 << m_owner) : 32'd0;
         check("busy", busy, e_busy);
         check("grant", grant, e_grant);
         check("cnt_init", cnt_init, (m_ph == PhStart || m_ph == PhRelease));
         check("done", done, e_done);
         check("timeout", timeout, m_to);
         if (grant != 0 && prev_grant == 0) begin g_log.push_back(grant); g_cyc.push_back(cyc); end
         if (done != 0) begin d_log.push_back(done); d_cyc.push_back(cyc); end
         if (timeout) t_cyc.push_back(cyc);
         if (s_fin && !prev_fin) f_cyc.push_back(cyc - 1);
         if (!busy && prev_busy) b_fall = cyc;
         prev_grant = grant; prev_busy = busy; prev_fin = s_fin;
      end
   end

   function automatic int log_size(input int which);
      case (which)
         0: return g_log.size();
         1: return d_log.size();
         2: return t_cyc.size();
         default: return busy ? 0 : 1;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input int n, input int budget);
      int k = 0;
      while (log_size(which) < n && k < budget) begin
         @(negedge clk_out);
         k++;
      end
      check(name, log_size(which) >= n, 1);
   endtask

   task automatic clear_logs();
      g_log.delete(); g_cyc.delete(); d_log.delete(); d_cyc.delete();
      t_cyc.delete(); f_cyc.delete(); b_fall = -1;
   endtask

   initial begin : stim
      int t_req;
      logic [N-1:0] exp_order[5];
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      repeat (3) @(negedge clk_out);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_init", cnt_init, 0);
      reset = 1'b0;
      @(negedge clk_out);

      // Single request, normal 15-step count.
      req = 4'b0001; t_req = cyc;
      wait_for("t1_wait_done", 1, 1, 60);
      check("t1_grant", g_log[0], 4'b0001);
      check("t1_grant_lat", g_cyc[0], t_req + 1);
      check("t1_done_idx", d_log[0], 4'b0001);
      check("t1_done_lat", d_cyc[0], g_cyc[0] + 16);
      check("t1_done_after_fin", d_cyc[0], f_cyc[0] + 1);
      check("t1_second_init", cnt_init, 1);
      req = '0;
      wait_for("t1_idle", 3, 1, 20);

      // All requesting from reset: strict rotation with back-to-back service.
      reset = 1'b1;
      repeat (2) @(negedge clk_out);
      reset = 1'b0;
      clear_logs();
      req = 4'b1111;
      wait_for("t2_wait_done", 1, 5, 150);
      req = '0;
      wait_for("t2_idle", 3, 1, 20);
      check("t2_grants", g_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t2_grant%0d", i), g_log[i], exp_order[i]);
         check($sformatf("t2_done%0d", i), d_log[i], exp_order[i]);
         if (i > 0) check($sformatf("t2_gap%0d", i), g_cyc[i] - g_cyc[i-1], 19);
      end

      // Two requesters after index 0 was last served.
      clear_logs();
      req = 4'b0101;
      wait_for("t3_wait_done", 1, 2, 80);
      req = '0;
      wait_for("t3_idle", 3, 1, 20);
      check("t3_first", g_log[0], 4'b0100);
      check("t3_second", g_log[1], 4'b0001);

      // Stuck counter: watchdog abort, no done, next requester served.
      clear_logs();
      cd_stuck = 1;
      req = 4'b0110;
      wait_for("t4_wait_timeout", 2, 1, 120);
      repeat (2) @(negedge clk_out);
      cd_stuck = 0;
      check("t4_owner", g_log[0], 4'b0010);
      check("t4_to_lat", t_cyc[0], g_cyc[0] + 65);
      check("t4_no_done", d_log.size(), 0);
      wait_for("t4_wait_done", 1, 1, 60);
      req = '0;
      check("t4_next", g_log[1], 4'b0100);
      check("t4_next_lat", g_cyc[1], t_cyc[0] + 3);
      check("t4_next_done", d_log[0], 4'b0100);
      wait_for("t4_idle", 3, 1, 20);

      // Reset while waiting for the count; pointer returns to N_REQ-1.
      clear_logs();
      req = 4'b1000;
      wait_for("t5_wait_grant", 0, 1, 10);
      repeat (5) @(negedge clk_out);
      reset = 1'b1; req = '0;
      @(posedge clk_out); #1;
      check("t5_rst_grant", grant, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_init", cnt_init, 0);
      @(negedge clk_out);
      @(negedge clk_out);
      reset = 1'b0;
      req = 4'b1010;
      wait_for("t5_wait_done", 1, 1, 60);
      req = '0;
      check("t5_first", g_log[0], 4'b1000);
      check("t5_after_rst", g_log[1], 4'b0010);
      check("t5_done", d_log[0], 4'b0010);
      wait_for("t5_idle", 3, 1, 20);

      // Owner drops req mid-count; finalSignal lingers three extra cycles.
      clear_logs();
      cd_hold = 3;
      req = 4'b0100;
      wait_for("t6_wait_grant", 0, 1, 10);
      repeat (3) @(negedge clk_out);
      req = '0;
      wait_for("t6_wait_done", 1, 1, 60);
      check("t6_done", d_log[0], 4'b0100);
      check("t6_done_lat", d_cyc[0], g_cyc[0] + 16);
      wait_for("t6_idle", 3, 1, 20);
      check("t6_idle_lat", b_fall, d_cyc[0] + 4);
      cd_hold = 0;

      repeat (3) @(negedge clk_out);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin : guard
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
